// File: rtl/tdpr_be_ram.sv
// True dual-port RAM with per-byte write enables, per-port read-during-write
// mode, optional output register and collision tracking.
module tdpr_be_ram #(
    parameter int ADDR_SIZE = 8,
    parameter int DATA_SIZE = 32,
    parameter int RAM_SIZE  = 1 << ADDR_SIZE,
    parameter int WR_MODE_A = 0,
    parameter int WR_MODE_B = 0,
    parameter int OUT_REG   = 0,
    parameter int CNT_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en_a,
    input  logic [DATA_SIZE/8-1:0] we_a,
    input  logic [ADDR_SIZE-1:0]   addr_a,
    input  logic [DATA_SIZE-1:0]   din_a,
    output logic [DATA_SIZE-1:0]   dout_a,
    output logic                   vld_a,
    input  logic                   en_b,
    input  logic [DATA_SIZE/8-1:0] we_b,
    input  logic [ADDR_SIZE-1:0]   addr_b,
    input  logic [DATA_SIZE-1:0]   din_b,
    output logic [DATA_SIZE-1:0]   dout_b,
    output logic                   vld_b,
    input  logic                   coll_clr,
    output logic                   coll_flag,
    output logic [CNT_WIDTH-1:0]   coll_cnt
);
    localparam int NB = DATA_SIZE / 8;

    typedef enum int {
        READ_FIRST  = 0,
        WRITE_FIRST = 1,
        NO_CHANGE   = 2
    } wr_mode_e;

    localparam wr_mode_e MODE_A = wr_mode_e'(WR_MODE_A);
    localparam wr_mode_e MODE_B = wr_mode_e'(WR_MODE_B);

    logic [DATA_SIZE-1:0] mem [RAM_SIZE];

    logic                 wr_a, wr_b, same, coll;
    logic [DATA_SIZE-1:0] old_a, old_b, fin_a, fin_b;
    logic [DATA_SIZE-1:0] nxt_a, nxt_b, q_a, q_b;
    logic                 nv_a, nv_b, qv_a, qv_b;

    assign wr_a  = en_a && (we_a != '0);
    assign wr_b  = en_b && (we_b != '0);
    assign same  = en_a && en_b && (addr_a == addr_b);
    assign coll  = same && (wr_a || wr_b);
    assign old_a = mem[addr_a];
    assign old_b = mem[addr_b];

    // Word as stored after the edge, as seen from each port; A wins shared bytes.
    always_comb begin
        fin_a = old_a;
        fin_b = old_b;
        for (int unsigned i = 0; i < NB; i++) begin
            if (same && wr_b && we_b[i]) fin_a[8*i +: 8] = din_b[8*i +: 8];
            if (wr_a && we_a[i])         fin_a[8*i +: 8] = din_a[8*i +: 8];
            if (wr_b && we_b[i])         fin_b[8*i +: 8] = din_b[8*i +: 8];
            if (same && wr_a && we_a[i]) fin_b[8*i +: 8] = din_a[8*i +: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int unsigned i = 0; i < NB; i++) begin
                if (wr_a && we_a[i])
                    mem[addr_a][8*i +: 8] <= din_a[8*i +: 8];
                if (wr_b && we_b[i] && !(same && wr_a && we_a[i]))
                    mem[addr_b][8*i +: 8] <= din_b[8*i +: 8];
            end
        end
    end

    always_comb begin
        nxt_a = q_a;
        nv_a  = 1'b0;
        if (en_a) begin
            if (!wr_a || MODE_A == READ_FIRST) begin
                nxt_a = old_a;
                nv_a  = 1'b1;
            end else if (MODE_A == WRITE_FIRST) begin
                nxt_a = fin_a;
                nv_a  = 1'b1;
            end
        end
    end

    always_comb begin
        nxt_b = q_b;
        nv_b  = 1'b0;
        if (en_b) begin
            if (!wr_b || MODE_B == READ_FIRST) begin
                nxt_b = old_b;
                nv_b  = 1'b1;
            end else if (MODE_B == WRITE_FIRST) begin
                nxt_b = fin_b;
                nv_b  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_a  <= '0;
            q_b  <= '0;
            qv_a <= 1'b0;
            qv_b <= 1'b0;
        end else begin
            q_a  <= nxt_a;
            q_b  <= nxt_b;
            qv_a <= nv_a;
            qv_b <= nv_b;
        end
    end

    generate
        if (OUT_REG != 0) begin : g_pipe
            always_ff @(posedge clk) begin
                if (rst) begin
                    dout_a <= '0;
                    dout_b <= '0;
                    vld_a  <= 1'b0;
                    vld_b  <= 1'b0;
                end else begin
                    dout_a <= q_a;
                    dout_b <= q_b;
                    vld_a  <= qv_a;
                    vld_b  <= qv_b;
                end
            end
        end else begin : g_direct
            assign dout_a = q_a;
            assign dout_b = q_b;
            assign vld_a  = qv_a;
            assign vld_b  = qv_b;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            coll_flag <= 1'b0;
            coll_cnt  <= '0;
        end else if (coll_clr) begin
            coll_flag <= coll;
            coll_cnt  <= coll ? CNT_WIDTH'(1) : '0;
        end else if (coll) begin
            coll_flag <= 1'b1;
            if (coll_cnt != '1) coll_cnt <= coll_cnt + CNT_WIDTH'(1);
        end
    end
endmodule

// File: doc/tdpr_be_ram.md
# tdpr_be_ram

Parametrised true dual-port RAM: the next generation of the team's `True_DPR` block. Two independent read/write ports share one clock and one storage array, with:

- per-byte write enables;
- a per-port read-during-write mode;
- an optional output pipeline register with aligned valid strobes;
- collision detection with a sticky flag and a saturating event counter.

It serves as the shared buffer between producer/consumer engines that need simultaneous random access.

## Interface

Parameters:
- ADDR_SIZE, 8, address width.
- DATA_SIZE, 32, word width. Must be a multiple of 8. NB = DATA_SIZE/8.
- RAM_SIZE, 1<<ADDR_SIZE, number of words.
- WR_MODE_A, 0, port A read-during-write mode: 0 READ_FIRST, 1 WRITE_FIRST, 2 NO_CHANGE.
- WR_MODE_B, 0, same for port B.
- OUT_REG, 0, 1 adds one output pipeline stage on both ports.
- CNT_WIDTH, 8, collision counter width.

Ports:
- clk, in, 1, single clock. All logic on posedge.
- rst, in, 1. Reset is synchronous and active-high.
- en_a / en_b, in, 1, port enable.
- we_a / we_b, in, NB, byte write mask. Zero means read; nonzero means write.
- addr_a / addr_b, in, ADDR_SIZE, word address.
- din_a / din_b, in, DATA_SIZE, write data.
- dout_a / dout_b, out, DATA_SIZE, read data.
- vld_a / vld_b, out, 1, dout updated this cycle.
- coll_clr, in, 1, synchronous clear of the collision flag and counter.
- coll_flag, out, 1, sticky collision indicator.
- coll_cnt, out, CNT_WIDTH, saturating collision count.

## Operation

Reset:
- While rst=1, both ports are ignored: no array writes.
- dout_a, dout_b, vld_a, vld_b, coll_flag and coll_cnt go to 0, including the pipeline stage.
- Array contents are not initialised and persist through reset.

Write:
- Write cycle: en=1, we≠0. Byte i of mem[addr] takes din[8i+7:8i] where we[i]=1; the other bytes are untouched.

Read:
- Read cycle: en=1, we=0. dout takes the pre-edge content of mem[addr]. vld=1.

Same-port write, data seen on dout:
- READ_FIRST: old word, vld=1.
- WRITE_FIRST: the word as stored after this edge, vld=1.
- NO_CHANGE: dout holds, vld=0.

Port disabled (en=0):
- dout holds its last value and vld=0.
- dout is never tri-stated.

Collision event: en_a && en_b && addr_a==addr_b && (we_a|we_b)≠0.
- Write/write: per byte, port A wins where both masks are set. Disjoint bytes merge.
- A WRITE_FIRST port in a write/write collision returns the final stored word.
- Cross-port read/write: the reading port always returns the old word, regardless of mode.
- Read/read on the same address is not a collision.

Collision tracking:
- Each collision event sets coll_flag and increments coll_cnt, saturating at 2^CNT_WIDTH−1.
- coll_clr with no event in the same cycle: flag=0, cnt=0.
- coll_clr and an event in the same cycle: flag=1, cnt=1.

## Timing

- OUT_REG=0: the access at edge N produces dout/vld valid after edge N, so read latency is 1.
- OUT_REG=1: the same data appears one edge later, so read latency is 2. vld stays aligned with dout.
- Back-to-back accesses every cycle on both ports give full throughput, with no stalls.
- A write at edge N is visible to a read on either port issued at edge N+1 or later.
- coll_flag/coll_cnt update on the edge after the colliding request. They are not delayed by OUT_REG.
- rst asserted mid-pipeline (OUT_REG=1): the in-flight read is dropped and vld stays 0 until the first post-reset access completes.

## Test plan

- Basic port-swap:
  - Stimulus: after reset, A writes 0xDEADBEEF @0x10 with we=0xF; next cycle B reads 0x10.
  - Required: dout_b=0xDEADBEEF, vld_b=1 one cycle later (two with OUT_REG=1). All outputs were 0 during reset.
- Byte enables:
  - Stimulus: mem[0x20]=0x11223344; A writes din=0xAABBCCDD with we=0x5; then A reads 0x20.
  - Required: dout_a=0x11BB33DD.
- Same-port read-during-write modes:
  - Stimulus: mem[5]=0x1; port writes 0x2 @5, run once per mode.
  - Required: READ_FIRST gives dout=0x1, vld=1. WRITE_FIRST gives dout=0x2, vld=1. NO_CHANGE holds the previous dout with vld=0. mem[5]=0x2 in all cases.
- Write/write collision:
  - Stimulus: A writes 0xAAAAAAAA with we=0x3 and B writes 0xBBBBBBBB with we=0xE, both @7.
  - Required: mem[7]=0xBBBBAAAA, coll_flag=1, coll_cnt=1.
- Cross-port read/write:
  - Stimulus: mem[9]=0x55; A reads 9 while B writes 0x66 @9.
  - Required: dout_a=0x55, mem[9]=0x66, coll_cnt increments.
- Saturation and clear (CNT_WIDTH=2):
  - Stimulus: 5 consecutive collisions, then coll_clr alone, then coll_clr together with a collision.
  - Required: cnt=3 after the collisions, then flag=0/cnt=0 after the lone clear, then flag=1/cnt=1.
